// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the IF stage: instruction classes, opcodes and IF state encoding.
package instruction_fetch_stage_pkg;

  typedef enum logic [3:0] {
    TypeNop     = 4'd0,
    TypeRtype   = 4'd1,
    TypeIalu    = 4'd2,
    TypeLoad    = 4'd3,
    TypeStore   = 4'd4,
    TypeBranch  = 4'd5,
    TypeJump    = 4'd6,
    TypeHalt    = 4'd7,
    TypeIllegal = 4'd15
  } inst_type_e;

  localparam logic [5:0] OpRtype       = 6'h00;
  localparam logic [5:0] OpJ           = 6'h02;
  localparam logic [5:0] OpJal         = 6'h03;
  localparam logic [5:0] OpBeq         = 6'h04;
  localparam logic [5:0] OpBne         = 6'h05;
  localparam logic [5:0] OpLoad        = 6'h23;
  localparam logic [5:0] OpStore       = 6'h2B;
  localparam logic [5:0] OpHaltDefault = 6'h3F;

  localparam logic [31:0] NopWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StHalted = 2'd1,
    StFault  = 2'd2
  } if_state_e;

endpackage

// File: rtl/instruction_fetch_stage_predecode.sv
// Combinational pre-decode of a fetched word into its instruction class.
module instruction_fetch_stage_predecode
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [5:0] HALT_OP = OpHaltDefault
) (
  input  logic [31:0] inst,
  output logic [3:0]  inst_type
);

  logic [5:0] op;
  assign op = inst[31:26];

  // Classify by opcode; the all-zero word is a NOP before any opcode rule applies.
  always_comb begin
    inst_type = TypeIllegal;
    if (inst == NopWord) begin
      inst_type = TypeNop;
    end else if (op == HALT_OP) begin
      inst_type = TypeHalt;
    end else if (op == OpRtype) begin
      inst_type = TypeRtype;
    end else if (op[5:3] == 3'b001) begin
      inst_type = TypeIalu;
    end else if (op == OpLoad) begin
      inst_type = TypeLoad;
    end else if (op == OpStore) begin
      inst_type = TypeStore;
    end else if (op == OpBeq || op == OpBne) begin
      inst_type = TypeBranch;
    end else if (op == OpJ || op == OpJal) begin
      inst_type = TypeJump;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC, sequence tag and run/halt/fault state, plus the FromIF bundle to IF/ID.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = OpHaltDefault
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_Data,
  output logic [31:0] FromIF_Inst,
  output logic [31:0] FromIF_NewPC,
  output logic [3:0]  FromIF_InstNum,
  output logic [3:0]  FromIF_InstType,
  output logic        Halted,
  output logic        Fault
);

  logic [31:0] pc_q, pc_d;
  logic [3:0]  seq_q, seq_d;
  if_state_e   state_q, state_d;
  logic        bubble;

  // Squash the fetch while in reset, when not running, or when this cycle's fetch is wrong-path.
  always_comb begin
    bubble          = reset || (state_q != StRun) || Redirect_Valid;
    FromIF_Inst     = bubble ? NopWord : Imem_Data;
    FromIF_NewPC    = pc_q + 32'd4;
    FromIF_InstNum  = seq_q;
    Imem_Addr       = pc_q;
    Halted          = (state_q == StHalted);
    Fault           = (state_q == StFault);
  end

  instruction_fetch_stage_predecode #(
    .HALT_OP (HALT_OP)
  ) u_predecode (
    .inst      (FromIF_Inst),
    .inst_type (FromIF_InstType)
  );

  // Next state: redirect beats stall; a stall simply holds everything so IF/ID re-captures it.
  always_comb begin
    pc_d    = pc_q;
    seq_d   = seq_q;
    state_d = state_q;
    if (Redirect_Valid && state_q != StFault) begin
      if (Redirect_Target[1:0] == 2'b00) begin
        pc_d    = Redirect_Target;
        state_d = StRun;
      end else begin
        state_d = StFault;
      end
    end else if (state_q == StRun && !Stall) begin
      seq_d = seq_q + 4'd1;
      if (FromIF_InstType == TypeHalt) begin
        // PC stays on the HALT so Imem_Addr points at it while halted.
        state_d = StHalted;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      seq_q   <= 4'd0;
      state_q <= StRun;
    end else begin
      pc_q    <= pc_d;
      seq_q   <= seq_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Randomized self-checking bench for instruction_fetch_stage against a behavioural model.
module tb_instruction_fetch_stage;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] from_if_inst;
  logic [31:0] from_if_newpc;
  logic [3:0]  from_if_instnum;
  logic [3:0]  from_if_insttype;
  logic        halted;
  logic        fault;

  logic [31:0] mem [0:1023];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: mode 0 = running, 1 = halted, 2 = faulted.
  logic [31:0] m_pc;
  logic [3:0]  m_seq;
  int          m_mode;

  instruction_fetch_stage #(
    .RESET_PC (ResetPc),
    .HALT_OP  (6'h3F)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .Stall           (stall),
    .Redirect_Valid  (redirect_valid),
    .Redirect_Target (redirect_target),
    .Imem_Addr       (imem_addr),
    .Imem_Data       (imem_data),
    .FromIF_Inst     (from_if_inst),
    .FromIF_NewPC    (from_if_newpc),
    .FromIF_InstNum  (from_if_instnum),
    .FromIF_InstType (from_if_insttype),
    .Halted          (halted),
    .Fault           (fault)
  );

  assign imem_data = mem[imem_addr[11:2]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_type(input logic [31:0] w);
    int op;
    op = int'(w[31:26]);
    if (w == 32'h0)                   return 4'd0;
    if (op == 'h3F)                   return 4'd7;
    if (op == 0)                      return 4'd1;
    if (op >= 8 && op <= 15)          return 4'd2;
    if (op == 'h23)                   return 4'd3;
    if (op == 'h2B)                   return 4'd4;
    if (op == 4 || op == 5)           return 4'd5;
    if (op == 2 || op == 3)           return 4'd6;
    return 4'd15;
  endfunction

  // Random non-HALT instruction word spanning every class.
  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = int'($urandom_range(0, 10));
    case (k)
      0:       w = 32'h0;
      1:       w[31:26] = 6'h00;
      2:       w[31:26] = 6'h23;
      3:       w[31:26] = 6'h2B;
      4:       w[31:26] = 6'(4 + $urandom_range(0, 1));
      5:       w[31:26] = 6'(2 + $urandom_range(0, 1));
      6:       w[31:26] = 6'h01;
      7:       w[31:26] = 6'h3E;
      default: w[31:26] = 6'(8 + $urandom_range(0, 7));
    endcase
    if (k != 0 && w == 32'h0) w = 32'h0000_0001;
    return w;
  endfunction

  function automatic logic [31:0] halt_word();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'h3F;
    return w;
  endfunction

  // One clock: drive at the falling edge, check the combinational bundle, advance the model.
  task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] tgt);
    logic        bub;
    logic [31:0] e_inst;
    logic [3:0]  e_type;
    @(negedge clock);
    reset           = rst;
    stall           = st;
    redirect_valid  = rv;
    redirect_target = tgt;
    if (rst) begin
      m_pc   = ResetPc;
      m_seq  = 4'd0;
      m_mode = 0;
    end
    #1;
    bub    = rst || (m_mode != 0) || rv;
    e_inst = bub ? 32'h0 : mem[m_pc[11:2]];
    e_type = ref_type(e_inst);
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("inst", from_if_inst, e_inst);
    check_eq("newpc", from_if_newpc, m_pc + 32'd4);
    check_eq("instnum", {28'h0, from_if_instnum}, {28'h0, m_seq});
    check_eq("insttype", {28'h0, from_if_insttype}, {28'h0, e_type});
    check_eq("halted", {31'h0, halted}, {31'h0, m_mode == 1});
    check_eq("fault", {31'h0, fault}, {31'h0, m_mode == 2});
    if (!rst) begin
      if (rv && m_mode != 2) begin
        if (tgt[1:0] == 2'b00) begin
          m_pc   = tgt;
          m_mode = 0;
        end else begin
          m_mode = 2;
        end
      end else if (m_mode == 0 && !st) begin
        m_seq = m_seq + 4'd1;
        if (e_type == 4'd7) m_mode = 1;
        else                m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    logic [31:0] tgt;
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    m_pc            = ResetPc;
    m_seq           = 4'd0;
    m_mode          = 0;
    for (int i = 0; i < 1024; i++) mem[i] = rand_word();

    // Reset state, then four free-running fetches.
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);

    // Stall twice at PC=8, then continue.
    step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    check_eq("pc_after_stall", m_pc, 32'h10);

    // Redirect under stall at PC=0x10.
    step(0, 1, 1, 32'h40);
    step(0, 0, 0, 0);

    // HALT at 0x20, halted cycles (with and without stall), then redirect out.
    mem[8] = halt_word();
    step(0, 0, 1, 32'h18);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h100);
    repeat (2) step(0, 0, 0, 0);

    // Misaligned redirect faults; later redirects ignored; reset clears.
    step(0, 0, 1, 32'h102);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h40);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // 17 consecutive fetches wrap the tag, then reset mid-stream.
    mem[8] = rand_word();
    repeat (17) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Randomized traffic with occasional HALTs, misaligned redirects and resets.
    for (int i = 0; i < 1024; i++) mem[i] = ($urandom_range(0, 49) == 0) ? halt_word() : rand_word();
    for (int i = 0; i < 800; i++) begin
      tgt = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 19) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      step($urandom_range(0, 99) < 2, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tgt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
